// File: rtl/vending_machine_if.sv
// Front-end/actuator bundle between the card reader, keypad and dispense hardware and the vending controller.
interface vending_machine_if;
  logic       CARD_IN;
  logic       VALID_TRAN;
  logic [3:0] ITEM_CODE;
  logic       KEY_PRESS;
  logic       DOOR_OPEN;
  logic       RELOAD;
  logic       VEND;
  logic       INVALID_SEL;
  logic       FAILED_TRAN;
  logic [2:0] COST;

  modport master (
    output CARD_IN, VALID_TRAN, ITEM_CODE, KEY_PRESS, DOOR_OPEN, RELOAD,
    input  VEND, INVALID_SEL, FAILED_TRAN, COST
  );

  modport slave (
    input  CARD_IN, VALID_TRAN, ITEM_CODE, KEY_PRESS, DOOR_OPEN, RELOAD,
    output VEND, INVALID_SEL, FAILED_TRAN, COST
  );
endinterface

// File: rtl/vending_machine.sv
// Card-operated vending controller: two-digit selection, price quote, bank approval,
// vend and door supervision, with per-slot stock counters for 20 slots.
module vending_machine (
  input  logic              CLK,
  input  logic              RESET,
  vending_machine_if.slave  bus
);

  localparam int unsigned NumSlots = 20;
  localparam int unsigned StockW   = 4;
  localparam int unsigned TimerW   = 3;
  localparam int unsigned SlotW    = 5;
  localparam int unsigned CodeW    = 8;
  localparam int unsigned CostW    = 3;

  localparam logic [StockW-1:0] StockFull   = StockW'(10);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(4);

  typedef enum logic [3:0] {
    RESET_S, IDLE, RELOAD_S, GET_MSD, GET_LSD, CHECK,
    WAIT_VALID, VEND_S, DOOR_WAIT, INVALID_S, FAILED_S
  } state_e;

  state_e             state_q;
  logic [TimerW-1:0]  timer_q;
  logic [3:0]         msd_q;
  logic [3:0]         lsd_q;
  logic [SlotW-1:0]   slot_q;
  logic [StockW-1:0]  stock_q [NumSlots];
  logic               vend_q;
  logic               invalid_q;
  logic               failed_q;
  logic [CostW-1:0]   cost_q;

  logic [CodeW-1:0]   code_c;
  logic               digits_ok_c;
  logic               in_range_c;
  logic [SlotW-1:0]   slot_c;
  logic               sel_ok_c;

  function automatic logic [CostW-1:0] price(input logic [SlotW-1:0] slot);
    if      (slot < SlotW'(4))  price = CostW'(1);
    else if (slot < SlotW'(8))  price = CostW'(2);
    else if (slot < SlotW'(12)) price = CostW'(3);
    else if (slot < SlotW'(16)) price = CostW'(4);
    else if (slot < SlotW'(18)) price = CostW'(5);
    else                        price = CostW'(6);
  endfunction

  // Selection decode; slot is forced to 0 when out of range so the stock lookup stays in bounds.
  always_comb begin
    code_c      = CodeW'(msd_q) * CodeW'(10) + CodeW'(lsd_q);
    digits_ok_c = (msd_q <= 4'd9) && (lsd_q <= 4'd9);
    in_range_c  = code_c < CodeW'(NumSlots);
    slot_c      = in_range_c ? code_c[SlotW-1:0] : '0;
    sel_ok_c    = digits_ok_c && in_range_c && (stock_q[slot_c] != '0);
  end

  // State, timer, stock and registered outputs; outputs are loaded with the decode of the state being entered.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= RESET_S;
      timer_q   <= '0;
      msd_q     <= '0;
      lsd_q     <= '0;
      slot_q    <= '0;
      vend_q    <= 1'b0;
      invalid_q <= 1'b0;
      failed_q  <= 1'b0;
      cost_q    <= '0;
      for (int i = 0; i < NumSlots; i++) stock_q[i] <= '0;
    end else begin
      vend_q    <= 1'b0;
      invalid_q <= 1'b0;
      failed_q  <= 1'b0;
      cost_q    <= '0;
      timer_q   <= timer_q + TimerW'(1);
      case (state_q)
        RESET_S: state_q <= IDLE;
        IDLE: begin
          if (bus.RELOAD) begin
            state_q <= RELOAD_S;
            for (int i = 0; i < NumSlots; i++) stock_q[i] <= StockFull;
          end else if (bus.CARD_IN) begin
            state_q <= GET_MSD;
            timer_q <= '0;
          end
        end
        RELOAD_S: begin
          if (bus.RELOAD) begin
            for (int i = 0; i < NumSlots; i++) stock_q[i] <= StockFull;
          end else begin
            state_q <= IDLE;
          end
        end
        GET_MSD: begin
          if (bus.KEY_PRESS) begin
            msd_q   <= bus.ITEM_CODE;
            state_q <= GET_LSD;
            timer_q <= '0;
          end else if (timer_q == TimeoutLast) begin
            state_q <= IDLE;
          end
        end
        GET_LSD: begin
          if (bus.KEY_PRESS) begin
            lsd_q   <= bus.ITEM_CODE;
            state_q <= CHECK;
          end else if (timer_q == TimeoutLast) begin
            state_q <= IDLE;
          end
        end
        CHECK: begin
          slot_q <= slot_c;
          if (sel_ok_c) begin
            state_q <= WAIT_VALID;
            timer_q <= '0;
            cost_q  <= price(slot_c);
          end else begin
            state_q   <= INVALID_S;
            invalid_q <= 1'b1;
          end
        end
        INVALID_S: state_q <= IDLE;
        // Approval on the final waiting edge still wins over the timeout.
        WAIT_VALID: begin
          if (bus.VALID_TRAN) begin
            state_q         <= VEND_S;
            timer_q         <= '0;
            stock_q[slot_q] <= stock_q[slot_q] - StockW'(1);
            vend_q          <= 1'b1;
            cost_q          <= cost_q;
          end else if (timer_q == TimeoutLast) begin
            state_q  <= FAILED_S;
            failed_q <= 1'b1;
          end else begin
            cost_q <= cost_q;
          end
        end
        VEND_S: begin
          if (bus.DOOR_OPEN) begin
            state_q <= DOOR_WAIT;
          end else if (timer_q == TimeoutLast) begin
            state_q <= IDLE;
          end else begin
            vend_q <= 1'b1;
            cost_q <= cost_q;
          end
        end
        DOOR_WAIT: if (!bus.DOOR_OPEN) state_q <= IDLE;
        FAILED_S:  state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign bus.VEND        = vend_q;
  assign bus.INVALID_SEL = invalid_q;
  assign bus.FAILED_TRAN = failed_q;
  assign bus.COST        = cost_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine: expected outputs per cycle are queued as stimulus is driven
// and compared against the DUT one cycle later.
module tb_vending_machine;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  vending_machine_if bus ();

  vending_machine dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [5:0] outs;   // {VEND, INVALID_SEL, FAILED_TRAN, COST}
  } exp_t;

  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_out(input string tag, input logic v, input logic i,
                            input logic f, input logic [2:0] c);
    exp_t e;
    e.tag  = tag;
    e.outs = {v, i, f, c};
    sb_q.push_back(e);
  endtask

  task automatic compare_front();
    exp_t       e;
    logic [5:0] obs;
    e   = sb_q.pop_front();
    obs = {bus.VEND, bus.INVALID_SEL, bus.FAILED_TRAN, bus.COST};
    checks++;
    assert (obs === e.outs) else begin
      errors++;
      $error("FAIL %s: observed vend/inv/fail/cost=%b expected %b", e.tag, obs, e.outs);
    end
  endtask

  // One clock: queue what the outputs must show after the coming edge, then compare.
  task automatic tick(input string tag, input logic v, input logic i,
                      input logic f, input logic [2:0] c);
    expect_out(tag, v, i, f, c);
    @(posedge CLK);
    #1;
    compare_front();
  endtask

  // Card in plus two digits; leaves the DUT in CHECK.
  task automatic select(input string tag, input logic [3:0] d1, input logic [3:0] d0);
    bus.CARD_IN = 1'b1;
    tick({tag, "_card"}, 0, 0, 0, 3'd0);
    bus.CARD_IN   = 1'b0;
    bus.ITEM_CODE = d1;
    bus.KEY_PRESS = 1'b1;
    tick({tag, "_msd"}, 0, 0, 0, 3'd0);
    bus.ITEM_CODE = d0;
    tick({tag, "_lsd"}, 0, 0, 0, 3'd0);
    bus.KEY_PRESS = 1'b0;
  endtask

  initial begin
    bus.CARD_IN    = 1'b0;
    bus.VALID_TRAN = 1'b0;
    bus.ITEM_CODE  = 4'd0;
    bus.KEY_PRESS  = 1'b0;
    bus.DOOR_OPEN  = 1'b0;
    bus.RELOAD     = 1'b0;

    #2 RESET = 1'b0;
    for (int k = 0; k < 10; k++) tick("reset_hold", 0, 0, 0, 3'd0);
    RESET = 1'b1;
    tick("reset_exit", 0, 0, 0, 3'd0);
    bus.RELOAD = 1'b1;
    tick("reload_enter", 0, 0, 0, 3'd0);
    bus.RELOAD = 1'b0;
    tick("reload_exit", 0, 0, 0, 3'd0);

    // Slot 00 stocked after reload: price 1, then approval timeout.
    select("sel00", 4'd0, 4'd0);
    tick("sel00_cost", 0, 0, 0, 3'd1);
    for (int k = 0; k < 4; k++) tick("sel00_wait", 0, 0, 0, 3'd1);
    tick("sel00_failed", 0, 0, 1, 3'd0);
    tick("sel00_idle", 0, 0, 0, 3'd0);

    // Card with no keypresses times out silently.
    bus.CARD_IN = 1'b1;
    tick("kto_card", 0, 0, 0, 3'd0);
    bus.CARD_IN = 1'b0;
    for (int k = 0; k < 10; k++) tick("kto_quiet", 0, 0, 0, 3'd0);

    // Normal vend of 14 with door cycle.
    select("v14", 4'd1, 4'd4);
    tick("v14_cost", 0, 0, 0, 3'd4);
    tick("v14_wait", 0, 0, 0, 3'd4);
    bus.VALID_TRAN = 1'b1;
    tick("v14_vend", 1, 0, 0, 3'd4);
    bus.VALID_TRAN = 1'b0;
    tick("v14_vend_hold", 1, 0, 0, 3'd4);
    bus.DOOR_OPEN = 1'b1;
    tick("v14_door", 0, 0, 0, 3'd0);
    tick("v14_door_hold", 0, 0, 0, 3'd0);
    bus.DOOR_OPEN = 1'b0;
    tick("v14_idle", 0, 0, 0, 3'd0);

    // Invalid selections.
    select("inv20", 4'd2, 4'd0);
    tick("inv20_sel", 0, 1, 0, 3'd0);
    tick("inv20_drop", 0, 0, 0, 3'd0);
    select("inv1_10", 4'd1, 4'd10);
    tick("inv1_10_sel", 0, 1, 0, 3'd0);
    tick("inv1_10_drop", 0, 0, 0, 3'd0);

    // No approval: FAILED_TRAN exactly 5 cycles after COST appears.
    select("f14", 4'd1, 4'd4);
    tick("f14_cost", 0, 0, 0, 3'd4);
    for (int k = 0; k < 4; k++) tick("f14_wait", 0, 0, 0, 3'd4);
    tick("f14_failed", 0, 0, 1, 3'd0);
    tick("f14_drop", 0, 0, 0, 3'd0);

    // Restock, held for two cycles.
    bus.RELOAD = 1'b1;
    tick("rl2_enter", 0, 0, 0, 3'd0);
    tick("rl2_hold", 0, 0, 0, 3'd0);
    bus.RELOAD = 1'b0;
    tick("rl2_exit", 0, 0, 0, 3'd0);

    // First vend of 14 never opens the door: VEND held 5 cycles, then idle.
    select("d14", 4'd1, 4'd4);
    tick("d14_cost", 0, 0, 0, 3'd4);
    bus.VALID_TRAN = 1'b1;
    tick("d14_vend", 1, 0, 0, 3'd4);
    bus.VALID_TRAN = 1'b0;
    for (int k = 0; k < 4; k++) tick("d14_vend_hold", 1, 0, 0, 3'd4);
    tick("d14_door_timeout", 0, 0, 0, 3'd0);

    // Nine more vends with varying approval delay, including approval on the final edge.
    for (int n = 1; n <= 9; n++) begin
      select("r14", 4'd1, 4'd4);
      tick("r14_cost", 0, 0, 0, 3'd4);
      for (int k = 0; k < (n % 5); k++) tick("r14_wait", 0, 0, 0, 3'd4);
      bus.VALID_TRAN = 1'b1;
      tick("r14_vend", 1, 0, 0, 3'd4);
      bus.VALID_TRAN = 1'b0;
      bus.DOOR_OPEN  = 1'b1;
      tick("r14_door", 0, 0, 0, 3'd0);
      bus.DOOR_OPEN  = 1'b0;
      tick("r14_idle", 0, 0, 0, 3'd0);
    end

    // Slot 14 now empty.
    select("e14", 4'd1, 4'd4);
    tick("e14_invalid", 0, 1, 0, 3'd0);
    tick("e14_drop", 0, 0, 0, 3'd0);

    // Reset mid-transaction drops outputs immediately and empties stock.
    select("mr00", 4'd0, 4'd0);
    tick("mr00_cost", 0, 0, 0, 3'd1);
    RESET = 1'b0;
    expect_out("mr_async_drop", 0, 0, 0, 3'd0);
    #1;
    compare_front();
    tick("mr_hold", 0, 0, 0, 3'd0);
    RESET = 1'b1;
    tick("mr_exit", 0, 0, 0, 3'd0);
    select("cl00", 4'd0, 4'd0);
    tick("cl00_invalid", 0, 1, 0, 3'd0);
    tick("cl00_drop", 0, 0, 0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
